// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: DATA_W data bits, OVS ticks per bit, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority vote around mid-bit.
module uart_rx_frame #(
  parameter int DATA_W      = 8,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_sclk,
  input  logic              i_rstn,
  input  logic              i_rx,
  input  logic              i_en,
  input  logic              i_par_en,
  input  logic              i_par_odd,
  input  logic              i_stop2,
  output logic [DATA_W-1:0] o_rxdata,
  output logic              o_rx_valid,
  output logic              o_rx_busy,
  output logic              o_par_err,
  output logic              o_frm_err,
  output logic              o_break
);

  localparam int TC_W = $clog2(OVS);
  localparam int BC_W = $clog2(DATA_W);

  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the mid+1 sample, so the start check lands one tick later
  // and every following bit decision inherits that one-tick shift.
  localparam logic [TC_W-1:0] TC_START = TC_W'(OVS / 2);
`else
  localparam logic [TC_W-1:0] TC_START = TC_W'(OVS / 2 - 1);
`endif
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic                   w_rxs;
  logic                   w_sample;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rxs_prev <= w_rxs;
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxs};
    end
  end

  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  assign w_sample = w_rxs;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [TC_W-1:0]     r_tc;
  logic [TC_W-1:0]     w_tc_next;
  logic [BC_W-1:0]     r_bc;
  logic [BC_W-1:0]     w_bc_next;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_next;
  logic                r_par_en;
  logic                r_par_odd;
  logic                r_stop2;
  logic                w_par_en_next;
  logic                w_par_odd_next;
  logic                w_stop2_next;
  logic                r_pbit;
  logic                w_pbit_next;
  logic                r_stop1_bit;
  logic                w_stop1_next;
  logic                w_frame_end;
  logic                w_tc_last;
  logic [TC_W-1:0]     w_tc_inc;

  logic [DATA_W-1:0]   r_rxdata;
  logic                r_rx_valid;
  logic                r_par_err;
  logic                r_frm_err;
  logic                r_break;
  logic                w_stop1_val;
  logic                w_par_err;
  logic                w_frm_err;
  logic                w_break;

  assign w_tc_last = (r_tc == TC_LAST);
  assign w_tc_inc  = r_tc + TC_W'(1);

  always_comb begin
    w_state_next   = r_state;
    w_tc_next      = r_tc;
    w_bc_next      = r_bc;
    w_shift_next   = r_shift;
    w_par_en_next  = r_par_en;
    w_par_odd_next = r_par_odd;
    w_stop2_next   = r_stop2;
    w_pbit_next    = r_pbit;
    w_stop1_next   = r_stop1_bit;
    w_frame_end    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_en && r_rxs_prev && !w_rxs) begin
          w_state_next   = S_START;
          w_tc_next      = '0;
          w_par_en_next  = i_par_en;
          w_par_odd_next = i_par_odd;
          w_stop2_next   = i_stop2;
        end
      end
      S_START: begin
        if (r_tc == TC_START) begin
          w_state_next = w_sample ? S_IDLE : S_DATA;
          w_tc_next    = '0;
          w_bc_next    = '0;
        end else begin
          w_tc_next = w_tc_inc;
        end
      end
      S_DATA: begin
        if (w_tc_last) begin
          w_shift_next = {w_sample, r_shift[DATA_W-1:1]};
          w_tc_next    = '0;
          if (r_bc == BC_LAST) begin
            w_state_next = r_par_en ? S_PARITY : S_STOP1;
          end else begin
            w_bc_next = r_bc + BC_W'(1);
          end
        end else begin
          w_tc_next = w_tc_inc;
        end
      end
      S_PARITY: begin
        if (w_tc_last) begin
          w_pbit_next  = w_sample;
          w_state_next = S_STOP1;
          w_tc_next    = '0;
        end else begin
          w_tc_next = w_tc_inc;
        end
      end
      S_STOP1: begin
        if (w_tc_last) begin
          w_stop1_next = w_sample;
          w_tc_next    = '0;
          if (r_stop2) begin
            w_state_next = S_STOP2;
          end else begin
            w_state_next = S_IDLE;
            w_frame_end  = 1'b1;
          end
        end else begin
          w_tc_next = w_tc_inc;
        end
      end
      S_STOP2: begin
        if (w_tc_last) begin
          w_state_next = S_IDLE;
          w_tc_next    = '0;
          w_frame_end  = 1'b1;
        end else begin
          w_tc_next = w_tc_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tc_next    = '0;
      end
    endcase

    // Disabling the receiver drops any frame in flight without reporting it.
    if (r_state != S_IDLE && !i_en) begin
      w_state_next = S_IDLE;
      w_tc_next    = '0;
      w_frame_end  = 1'b0;
    end
  end

  // In a one-stop frame the first stop is the sample taken this very cycle.
  assign w_stop1_val = (r_state == S_STOP1) ? w_sample : r_stop1_bit;
  assign w_par_err   = r_par_en & ((^r_shift ^ r_pbit) != r_par_odd);
  assign w_frm_err   = ~w_stop1_val | ~w_sample;
  assign w_break     = (r_shift == '0) & (~r_par_en | ~r_pbit) & ~w_stop1_val;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_tc        <= '0;
      r_bc        <= '0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_pbit      <= 1'b0;
      r_stop1_bit <= 1'b0;
      r_rxdata    <= '0;
      r_rx_valid  <= 1'b0;
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tc        <= w_tc_next;
      r_bc        <= w_bc_next;
      r_shift     <= w_shift_next;
      r_par_en    <= w_par_en_next;
      r_par_odd   <= w_par_odd_next;
      r_stop2     <= w_stop2_next;
      r_pbit      <= w_pbit_next;
      r_stop1_bit <= w_stop1_next;
      r_rx_valid  <= w_frame_end;
      if (w_frame_end) begin
        r_rxdata  <= r_shift;
        r_par_err <= w_par_err;
        r_frm_err <= w_frm_err;
        r_break   <= w_break;
      end
    end
  end

  assign o_rxdata   = r_rxdata;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_busy  = (r_state != S_IDLE);
  assign o_par_err  = r_par_err;
  assign o_frm_err  = r_frm_err;
  assign o_break    = r_break;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame (DATA_W=8, OVS=16, SYNC_STAGES=2): directed frames, expected results queued.
module tb_uart_rx_frame;

  localparam int DATA_W = 8;
  localparam int OVS    = 16;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              rx;
  logic              en;
  logic              par_en;
  logic              par_odd;
  logic              stop2;
  logic [DATA_W-1:0] rxdata;
  logic              rx_valid;
  logic              rx_busy;
  logic              par_err;
  logic              frm_err;
  logic              brk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  uart_rx_frame #(.DATA_W(DATA_W), .OVS(OVS), .SYNC_STAGES(SYNC)) dut (
    .i_sclk    (clk),
    .i_rstn    (rstn),
    .i_rx      (rx),
    .i_en      (en),
    .i_par_en  (par_en),
    .i_par_odd (par_odd),
    .i_stop2   (stop2),
    .o_rxdata  (rxdata),
    .o_rx_valid(rx_valid),
    .o_rx_busy (rx_busy),
    .o_par_err (par_err),
    .o_frm_err (frm_err),
    .o_break   (brk)
  );

  always #5 clk = ~clk;

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rx_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got data=%02h pe=%0b fe=%0b bk=%0b, required no frame",
                 rxdata, par_err, frm_err, brk);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rxdata, par_err, frm_err, brk} !== {e.d, e.pe, e.fe, e.bk}) begin
          errors++;
          $display("FAIL frame: got data=%02h pe=%0b fe=%0b bk=%0b, required data=%02h pe=%0b fe=%0b bk=%0b",
                   rxdata, par_err, frm_err, brk, e.d, e.pe, e.fe, e.bk);
        end else begin
          $display("frame ok: data=%02h pe=%0b fe=%0b bk=%0b", rxdata, par_err, frm_err, brk);
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check ok: %s = %0h", name, act);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (OVS - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                            input bit two_stop, input logic stop2_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(pbit);
    drive_bit(1'b1);
    if (two_stop) drive_bit(stop2_val);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    e.bk = bk;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d frames still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic set_cfg(input logic pe, input logic po, input logic s2);
    @(negedge clk);
    par_en  = pe;
    par_odd = po;
    stop2   = s2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rxdata"}, 32'(rxdata), 32'h0);
    check_eq({tag, "_valid"},  32'(rx_valid), 32'h0);
    check_eq({tag, "_busy"},   32'(rx_busy), 32'h0);
    check_eq({tag, "_par_err"}, 32'(par_err), 32'h0);
    check_eq({tag, "_frm_err"}, 32'(frm_err), 32'h0);
    check_eq({tag, "_break"},  32'(brk), 32'h0);
  endtask

  initial begin
    rstn    = 1'b0;
    rx      = 1'b1;
    en      = 1'b1;
    par_en  = 1'b0;
    par_odd = 1'b0;
    stop2   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2 * OVS) @(negedge clk);

    // 8N1 0xA5
    set_cfg(1'b0, 1'b0, 1'b0);
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("a5", 4 * OVS);
    check_eq("busy_after_a5", 32'(rx_busy), 32'h0);

    // 8E1 0x03: one set data bit count is even, so parity bit 1 is wrong, 0 is right
    set_cfg(1'b1, 1'b0, 1'b0);
    expect_frame(8'h03, 1'b1, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain("e1_bad", 4 * OVS);
    expect_frame(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("e1_good", 4 * OVS);

    // 8O2 0x55: four ones, odd parity bit 1 is correct; second stop low
    set_cfg(1'b1, 1'b1, 1'b1);
    expect_frame(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain("o2_stop", 4 * OVS);

    // Short low glitch in IDLE: enters START, rejects, no frame
    set_cfg(1'b0, 1'b0, 1'b0);
    repeat (2 * OVS) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check_eq("glitch_busy_high", 32'(rx_busy), 32'h1);
    repeat (OVS / 2 + SYNC + 4) @(negedge clk);
    check_eq("glitch_busy_low", 32'(rx_busy), 32'h0);
    repeat (2 * OVS) @(negedge clk);

    // Break: line low for three 8N1 frame times -> exactly one frame
    expect_frame(8'h00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (30 * OVS) @(negedge clk);
    rx = 1'b1;
    wait_drain("break", 4 * OVS);
    repeat (3 * OVS) @(negedge clk);
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("after_break", 4 * OVS);

    // Reset in the middle of the data bits, then a clean frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk);
    rstn = 1'b0;
    rx   = 1'b1;
    #1;
    check_idle_outputs("midreset");
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    expect_frame(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("after_reset", 4 * OVS);

    repeat (4 * OVS) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
